// File: rtl/intack_if.sv
// intack_if: groups the PIC-side (INT/INTA/data bus) and core-side
// (vector valid/ack) signals of the interrupt-acknowledge sequencer.
`default_nettype none

interface intack_if;
  logic       INT;
  logic       IE;
  logic [7:0] D_IN;
  logic       vec_ack;
  logic       INTA;
  logic [7:0] vector;
  logic       vec_valid;
  logic       busy;
  logic       spurious;

  modport master (
    input  INT, IE, D_IN, vec_ack,
    output INTA, vector, vec_valid, busy, spurious
  );

  modport slave (
    output INT, IE, D_IN, vec_ack,
    input  INTA, vector, vec_valid, busy, spurious
  );
endinterface

`default_nettype wire

// File: rtl/intack_master.sv
// +--------------------------------------------------------------------------+
// | intack_master: two-pulse 8259 INTA sequencer with vector valid/ack hand- |
// | off. Optional macro INTACK_SPURIOUS_EN adds the spurious-vector flag.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module intack_master #(
    parameter int LOW_CYCLES = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic     clk,
    input  logic     rst,
    intack_if.master bus
);

    localparam int c_MAX_LG = (LOW_CYCLES > GAP_CYCLES) ? LOW_CYCLES : GAP_CYCLES;
    localparam int c_MAX_N  = (c_MAX_LG > 3) ? c_MAX_LG : 3;
    localparam int c_CNT_W  = $clog2(c_MAX_N) + 1;

    localparam logic [c_CNT_W-1:0] c_LOW_LOAD = c_CNT_W'(LOW_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD = c_CNT_W'(GAP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_REC_LOAD = c_CNT_W'(2);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_P1      = 3'd1;
    localparam logic [2:0] c_GAP     = 3'd2;
    localparam logic [2:0] c_P2      = 3'd3;
    localparam logic [2:0] c_DONE    = 3'd4;
    localparam logic [2:0] c_RECOVER = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_cnt_zero;
    logic               r_sync1;
    logic               r_int_s;
    logic               r_inta;
    logic [7:0]         r_vector;
    logic               r_valid;
    logic               w_capture;
    logic               w_ack_take;

    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_int_s <= 1'b0;
        end else begin
            r_sync1 <= bus.INT;
            r_int_s <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_zero ? r_cnt : r_cnt - c_CNT_W'(1);
        w_capture   = 1'b0;
        w_ack_take  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (r_int_s && bus.IE && !r_valid) begin
                    w_state_nxt = c_P1;
                    w_cnt_nxt   = c_LOW_LOAD;
                end
            end
            c_P1: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_GAP;
                    w_cnt_nxt   = c_GAP_LOAD;
                end
            end
            c_GAP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_P2;
                    w_cnt_nxt   = c_LOW_LOAD;
                end
            end
            c_P2: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_DONE;
                    w_capture   = 1'b1;
                end
            end
            c_DONE: begin
                if (bus.vec_ack && r_valid) begin
                    w_state_nxt = c_RECOVER;
                    w_cnt_nxt   = c_REC_LOAD;
                    w_ack_take  = 1'b1;
                end
            end
            c_RECOVER: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inta   <= 1'b1;
            r_vector <= 8'h00;
            r_valid  <= 1'b0;
        end else begin
            r_inta <= !((w_state_nxt == c_P1) || (w_state_nxt == c_P2));
            if (w_capture) begin
                r_vector <= bus.D_IN;
                r_valid  <= 1'b1;
            end else if (w_ack_take) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef INTACK_SPURIOUS_EN
    logic r_spur_q;
    logic r_spur;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_spur_q <= 1'b0;
            r_spur   <= 1'b0;
        end else begin
            if ((r_state == c_GAP) && w_cnt_zero) begin
                r_spur_q <= !r_int_s;
            end
            if (w_capture) begin
                r_spur <= r_spur_q;
            end else if (w_ack_take) begin
                r_spur <= 1'b0;
            end
        end
    end

    assign bus.spurious = r_spur;
`else
    assign bus.spurious = 1'b0;
`endif

    assign bus.INTA      = r_inta;
    assign bus.vector    = r_vector;
    assign bus.vec_valid = r_valid;
    assign bus.busy      = (r_state != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_intack_master.sv
// Directed bench for intack_master: reset, basic, masked, back-to-back,
// backpressure, mid-P2 reset and spurious-flag scenarios.
`default_nettype none

module tb_intack_master;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  intack_if bus ();

  intack_master #(
    .LOW_CYCLES(4),
    .GAP_CYCLES(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Samples INTA over 10 consecutive cycles, first sample taken now.
  task automatic grab10(output logic [9:0] p);
    for (int i = 0; i < 10; i++) begin
      p[9-i] = bus.INTA;
      if (i < 9) tick(1);
    end
  endtask

  logic [9:0] pat;
  logic       ok;
  logic       spur_exp;

  initial begin
    total = 0;
    bad   = 0;
`ifdef INTACK_SPURIOUS_EN
    spur_exp = 1'b1;
`else
    spur_exp = 1'b0;
`endif
    rst         = 1'b1;
    bus.INT     = 1'b0;
    bus.IE      = 1'b0;
    bus.D_IN    = 8'h00;
    bus.vec_ack = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("rst_inta",     32'(bus.INTA),      32'h1);
    chk("rst_vector",   32'(bus.vector),    32'h00);
    chk("rst_valid",    32'(bus.vec_valid), 32'h0);
    chk("rst_busy",     32'(bus.busy),      32'h0);
    chk("rst_spurious", 32'(bus.spurious),  32'h0);

    // Basic sequence with vec_ack held high
    bus.IE = 1'b1; bus.D_IN = 8'h4B; bus.vec_ack = 1'b1; bus.INT = 1'b1;
    tick(1);
    chk("basic_k_inta", 32'(bus.INTA), 32'h1);
    tick(1);
    chk("basic_k1_inta", 32'(bus.INTA), 32'h1);
    chk("basic_k1_busy", 32'(bus.busy), 32'h0);
    tick(1);
    grab10(pat);
    chk("basic_pattern", 32'(pat), 32'h030);
    chk("basic_pre_valid", 32'(bus.vec_valid), 32'h0);
    tick(1);
    chk("basic_inta_high", 32'(bus.INTA),      32'h1);
    chk("basic_valid",     32'(bus.vec_valid), 32'h1);
    chk("basic_vector",    32'(bus.vector),    32'h4B);
    tick(1);
    chk("basic_valid_1clk", 32'(bus.vec_valid), 32'h0);
    chk("basic_recover_busy", 32'(bus.busy), 32'h1);
    bus.INT = 1'b0;
    tick(5);
    chk("basic_idle_busy", 32'(bus.busy), 32'h0);
    chk("basic_idle_inta", 32'(bus.INTA), 32'h1);

    // Masked: INT high with IE low for 20 clocks
    bus.vec_ack = 1'b0; bus.IE = 1'b0; bus.INT = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.INTA !== 1'b1 || bus.busy !== 1'b0) ok = 1'b0;
    end
    chk("masked_quiet", 32'(ok), 32'h1);
    bus.IE = 1'b1; bus.D_IN = 8'h48;
    tick(1);
    chk("masked_ie_fall", 32'(bus.INTA), 32'h0);

    // Back-to-back: 0x48 then 0x49 with INT held high
    tick(10);
    chk("b2b_valid0",  32'(bus.vec_valid), 32'h1);
    chk("b2b_vector0", 32'(bus.vector),    32'h48);
    bus.vec_ack = 1'b1; bus.D_IN = 8'h49;
    tick(1);
    chk("b2b_ack0", 32'(bus.vec_valid), 32'h0);
    bus.vec_ack = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (bus.INTA !== 1'b1) ok = 1'b0;
    end
    chk("b2b_recover_high", 32'(ok), 32'h1);
    tick(1);
    chk("b2b_second_fall", 32'(bus.INTA), 32'h0);
    tick(10);
    chk("b2b_valid1",  32'(bus.vec_valid), 32'h1);
    chk("b2b_vector1", 32'(bus.vector),    32'h49);

    // Backpressure: no ack for 50 clocks
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (bus.INTA !== 1'b1 || bus.vector !== 8'h49 || bus.vec_valid !== 1'b1) ok = 1'b0;
    end
    chk("bp_hold", 32'(ok), 32'h1);
    bus.vec_ack = 1'b1; bus.D_IN = 8'hA5;
    tick(1);
    chk("bp_ack", 32'(bus.vec_valid), 32'h0);
    bus.vec_ack = 1'b0;
    tick(3);
    chk("bp_still_high", 32'(bus.INTA), 32'h1);
    tick(1);
    chk("bp_restart_fall", 32'(bus.INTA), 32'h0);

    // Reset two clocks into P2
    tick(7);
    chk("rstp2_in_p2", 32'(bus.INTA), 32'h0);
    rst = 1'b1;
    tick(1);
    chk("rstp2_inta",   32'(bus.INTA),      32'h1);
    chk("rstp2_vector", 32'(bus.vector),    32'h00);
    chk("rstp2_valid",  32'(bus.vec_valid), 32'h0);
    chk("rstp2_busy",   32'(bus.busy),      32'h0);
    rst = 1'b0; bus.INT = 1'b0;
    tick(5);

    // Spurious: INT dropped during P1
    bus.INT = 1'b1; bus.D_IN = 8'h4F; bus.vec_ack = 1'b0;
    tick(3);
    chk("spur_p1_fall", 32'(bus.INTA), 32'h0);
    bus.INT = 1'b0;
    grab10(pat);
    chk("spur_pattern", 32'(pat), 32'h030);
    tick(1);
    chk("spur_valid",  32'(bus.vec_valid), 32'h1);
    chk("spur_vector", 32'(bus.vector),    32'h4F);
    chk("spur_flag",   32'(bus.spurious),  32'(spur_exp));
    bus.vec_ack = 1'b1;
    tick(1);
    chk("spur_clear_valid", 32'(bus.vec_valid), 32'h0);
    chk("spur_clear_flag",  32'(bus.spurious),  32'h0);
    bus.vec_ack = 1'b0;
    tick(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/intack_master.md
# intack_master

CPU-side interrupt-acknowledge sequencer for the 8259 subsystem. Watches the PIC's `INT` line, runs the two-pulse active-low `INTA` cycle, captures the 8-bit vector the PIC drives on the data bus during the second pulse, and hands it to the CPU core through a valid/ack handshake. It sits between the PIC's `INT`/`INTA`/data-bus pins and the core's interrupt-entry logic.

## Interface
- `LOW_CYCLES`, default 4: clocks `INTA` is held low per pulse. Must be ≥1.
- `GAP_CYCLES`, default 2: clocks `INTA` is held high between the two pulses. Must be ≥1.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `INT` in 1: interrupt request from the PIC; asynchronous, double-flop synchronized internally.
- `IE` in 1: core interrupt-enable (IF flag); gates the start of a sequence only.
- `D_IN` in 8: PIC data bus, sampled during the second pulse.
- `vec_ack` in 1: core has consumed `vector`.
- `INTA` out 1: acknowledge strobe to the PIC, active low, registered.
- `vector` out 8: captured interrupt vector.
- `vec_valid` out 1: `vector` holds an unconsumed vector.
- `busy` out 1: FSM not in IDLE.
- `spurious` out 1: captured vector flagged spurious; tied 0 without `INTACK_SPURIOUS_EN`.

## Operation
- Synchronizer: `int_s` = `INT` after two flops; the FSM uses only `int_s`.
- States: IDLE, P1 (`INTA`=0), GAP (`INTA`=1), P2 (`INTA`=0), DONE, RECOVER.
- IDLE → P1 when `int_s`=1, `IE`=1 and `vec_valid`=0.
- P1 → GAP after `LOW_CYCLES` clocks; GAP → P2 after `GAP_CYCLES` clocks; P2 → DONE after `LOW_CYCLES` clocks.
- Capture: on the last P2 clock, `D_IN` is registered into `vector`. `vec_valid` rises on the same edge that `INTA` returns high.
- DONE: hold `vector`/`vec_valid` until `vec_ack`=1 is sampled with `vec_valid`=1. On that edge `vec_valid`→0 and the FSM → RECOVER.
- RECOVER: 3 clocks, fixed. This flushes the synchronizer so that the PIC's `INT` drop (at `INTA` rising) is seen before re-arming. Then → IDLE.
- One shared down-counter of width `$clog2(max(LOW_CYCLES,GAP_CYCLES,3))+1`. It is loaded on each state entry; the state advances when the counter reaches 0.
- Once in P1, the pair always completes. Later changes on `IE` or `INT` do not abort it, because the PIC protocol requires both pulses.
- `vec_ack` outside DONE is ignored.
- `busy`=1 in every state except IDLE.

## Timing
- Reset values: `INTA`=1, `vector`=8'h00, `vec_valid`=0, `busy`=0, `spurious`=0, state IDLE, synchronizer flops 0.
- `rst` mid-sequence: `INTA`=1 from the next edge, and any partial vector is discarded.
- Start latency: `INT` rises before edge k → `int_s`=1 after edge k+1 → `INTA` low from edge k+2, provided `IE`=1.
- Pulse train: `LOW_CYCLES` low, `GAP_CYCLES` high, `LOW_CYCLES` low. With defaults this is 4/2/4.
- Total from first `INTA` fall to `vec_valid`=1: 2·`LOW_CYCLES`+`GAP_CYCLES` clocks, which is 10 with defaults.
- `vec_ack` in the first DONE cycle: `vec_valid` is high for exactly 1 clock.
- Earliest next `INTA` fall: 4 clocks after the `vec_ack` edge (1 DONE→RECOVER edge, 3 RECOVER clocks).

## Configuration
- `INTACK_SPURIOUS_EN` defined:
  - On the last GAP clock, register `spur_q` = !`int_s`.
  - At capture, `spurious` = `spur_q` and is cleared together with `vec_valid`.
  - The vector value is still whatever the PIC drives; the PIC returns IR7 on a dropped request.
- Not defined: `spurious` is constant 0 and there is no `spur_q` flop.

## Test plan
- Basic: `IE`=1, `D_IN`=8'h4B, `INT` 0→1 → `INTA` low 4 / high 2 / low 4; `vector`=8'h4B, `vec_valid`=1; with `vec_ack` held at 1, `vec_valid` is high for exactly 1 clock.
- Masked: `INT`=1, `IE`=0 for 20 clocks → `INTA` stays 1 and `busy`=0. Raise `IE` → `INTA` falls on the next edge.
- Back-to-back: `INT` held 1, `vec_ack` pulsed as each vector appears, `D_IN` 8'h48 then 8'h49 → two complete 10-clock sequences separated by ≥4 `INTA`-high clocks after each ack; vectors arrive in order.
- Backpressure: `vec_ack`=0 for 50 clocks with `INT`=1 → no new `INTA` pulses and `vector` stable. Ack → the next sequence starts 4 clocks later.
- Reset mid-P2: assert `rst` 2 clocks into P2 → `INTA`=1, `vector`=8'h00, `vec_valid`=0 on the next edge.
- Spurious (macro on): drop `INT` during P1, `D_IN`=8'h4F → both pulses still issued; `vector`=8'h4F with `spurious`=1. Macro off, same stimulus → `spurious`=0.
